// File: rtl/bus_responder_pkg.sv
// bus_responder_pkg: shared state encoding and constants for the 65C02 bus responder.
package bus_responder_pkg;
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_WAIT = 2'd1;
   localparam state_t S_DONE = 2'd2;
   localparam logic [15:0] VEC_NMI_LO = 16'hFFFA;
   localparam logic [15:0] VEC_RST_LO = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ_LO = 16'hFFFE;
   localparam logic [7:0]  NOP_OPCODE = 8'hEA;
endpackage

// File: rtl/bus_vector_rom.sv
// bus_vector_rom: combinational byte select for the NMI/RST/IRQ vectors at FFFA-FFFF.
module bus_vector_rom #(
   parameter logic [15:0] NMI_VEC = 16'hE100,
   parameter logic [15:0] RST_VEC = 16'hE000,
   parameter logic [15:0] IRQ_VEC = 16'hE200
) (
   input  logic [15:0] addr,
   output logic        hit,
   output logic [7:0]  data
);
   import bus_responder_pkg::*;
   logic [15:0] vec;
   always_comb begin
      vec  = addr >= VEC_IRQ_LO ? IRQ_VEC : addr >= VEC_RST_LO ? RST_VEC : NMI_VEC;
      hit  = addr >= VEC_NMI_LO;
      data = addr[0] ? vec[15:8] : vec[7:0];
   end
endmodule

// File: rtl/bus_responder.sv
// bus_responder: turns each 65C02 phi2 bus cycle into a req/ack memory transaction.
// Define BUS_RESPONDER_VECTOR_OVERRIDE_EN to answer FFFA-FFFF vector pulls locally.
module bus_responder #(
   parameter logic [7:0]  TIMEOUT = 8'd255,
   parameter logic [15:0] NMI_VEC = 16'hE100,
   parameter logic [15:0] RST_VEC = 16'hE000,
   parameter logic [15:0] IRQ_VEC = 16'hE200
) (
   input  logic        fclk,
   input  logic        resb,
   input  logic        phi2,
   input  logic [15:0] addr,
   input  logic        rwb,
   input  logic        sync,
   input  logic        vpb,
   input  logic        mlb,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rdata_oe,
   output logic        rdy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        mem_lock,
   output logic        bus_err,
   output logic [15:0] last_fetch
);
   import bus_responder_pkg::*;
   state_t      state_q, state_d;
   logic        phi2_dly_q, phi2_dly_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rdata_oe_q, rdata_oe_d;
   logic        rdy_q, rdy_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        mem_lock_q, mem_lock_d;
   logic        bus_err_q, bus_err_d;
   logic [15:0] last_fetch_q, last_fetch_d;
   logic        rd_q, rd_d;
   logic        launch, finish, vec_hit;
   logic [7:0]  vec_byte;
`ifdef BUS_RESPONDER_VECTOR_OVERRIDE_EN
   logic rom_hit;
   bus_vector_rom #(.NMI_VEC(NMI_VEC), .RST_VEC(RST_VEC), .IRQ_VEC(IRQ_VEC)) u_rom (
      .addr (addr),
      .hit  (rom_hit),
      .data (vec_byte)
   );
   assign vec_hit = rwb && !vpb && rom_hit;
`else
   logic unused_vec;
   assign unused_vec = ^{vpb, NMI_VEC, RST_VEC, IRQ_VEC, VEC_NMI_LO, VEC_RST_LO, VEC_IRQ_LO};
   assign vec_hit    = 1'b0;
   assign vec_byte   = NOP_OPCODE;
`endif
   assign launch = state_q == S_IDLE && phi2 && !phi2_dly_q;
   // ack has priority over a timeout landing on the same cycle
   assign finish = mem_ack || cnt_q + 8'd1 == TIMEOUT;
   always_comb begin
      state_d      = state_q;
      phi2_dly_d   = phi2;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      rdata_oe_d   = rdata_oe_q;
      rdy_d        = rdy_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_lock_d   = mem_lock_q;
      bus_err_d    = bus_err_q;
      last_fetch_d = last_fetch_q;
      rd_d         = rd_q;
      if (launch) begin
         mem_lock_d   = ~mlb;
         last_fetch_d = sync ? addr : last_fetch_q;
         if (vec_hit) begin
            rdata_d    = vec_byte;
            rdata_oe_d = 1'b1;
            state_d    = S_DONE;
         end else begin
            mem_addr_d  = addr;
            mem_we_d    = ~rwb;
            mem_wdata_d = wdata;
            mem_req_d   = 1'b1;
            rdy_d       = 1'b0;
            rd_d        = rwb;
            cnt_d       = 8'd0;
            state_d     = S_WAIT;
         end
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q + 8'd1;
         if (finish) begin
            mem_req_d  = 1'b0;
            rdy_d      = 1'b1;
            bus_err_d  = bus_err_q || !mem_ack;
            rdata_d    = rd_q ? (mem_ack ? mem_rdata : NOP_OPCODE) : rdata_q;
            rdata_oe_d = rd_q;
            state_d    = S_DONE;
         end
      end else if (state_q == S_DONE && !phi2) begin
         rdata_oe_d = 1'b0;
         state_d    = S_IDLE;
      end
   end
   always_ff @(posedge fclk or negedge resb)
      if (!resb) begin
         state_q      <= S_IDLE;
         phi2_dly_q   <= 1'b1;
         cnt_q        <= 8'd0;
         rdata_q      <= 8'd0;
         rdata_oe_q   <= 1'b0;
         rdy_q        <= 1'b1;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 16'd0;
         mem_wdata_q  <= 8'd0;
         mem_lock_q   <= 1'b0;
         bus_err_q    <= 1'b0;
         last_fetch_q <= 16'd0;
         rd_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         phi2_dly_q   <= phi2_dly_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         rdata_oe_q   <= rdata_oe_d;
         rdy_q        <= rdy_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_lock_q   <= mem_lock_d;
         bus_err_q    <= bus_err_d;
         last_fetch_q <= last_fetch_d;
         rd_q         <= rd_d;
      end
   assign rdata      = rdata_q;
   assign rdata_oe   = rdata_oe_q;
   assign rdy        = rdy_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_lock   = mem_lock_q;
   assign bus_err    = bus_err_q;
   assign last_fetch = last_fetch_q;
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: table-driven plus randomized transaction checks of bus_responder.
module tb_bus_responder;
   localparam int T = 16;
   logic        fclk = 1'b0, resb = 1'b0, phi2 = 1'b1, rwb = 1'b1, sync = 1'b0, vpb = 1'b1, mlb = 1'b1;
   logic [15:0] addr = 16'd0;
   logic [7:0]  wdata = 8'd0, mem_rdata = 8'd0;
   logic        mem_ack = 1'b0;
   logic [7:0]  rdata, mem_wdata;
   logic        rdata_oe, rdy, mem_req, mem_we, mem_lock, bus_err;
   logic [15:0] mem_addr, last_fetch;
   int nvec = 0, nmis = 0;
   logic [7:0]  m_rdata = 8'd0;
   logic        m_err = 1'b0;
   logic [15:0] m_lf = 16'd0;

   bus_responder #(.TIMEOUT(8'd16)) dut (
      .fclk(fclk), .resb(resb), .phi2(phi2), .addr(addr), .rwb(rwb), .sync(sync), .vpb(vpb),
      .mlb(mlb), .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe), .rdy(rdy), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .mem_lock(mem_lock), .bus_err(bus_err), .last_fetch(last_fetch)
   );

   always #5 fclk = ~fclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_rdata"}, {8'd0, rdata}, 16'd0);
      chk({p, "_rdata_oe"}, {15'd0, rdata_oe}, 16'd0);
      chk({p, "_rdy"}, {15'd0, rdy}, 16'd1);
      chk({p, "_mem_req"}, {15'd0, mem_req}, 16'd0);
      chk({p, "_mem_we"}, {15'd0, mem_we}, 16'd0);
      chk({p, "_mem_addr"}, mem_addr, 16'd0);
      chk({p, "_mem_wdata"}, {8'd0, mem_wdata}, 16'd0);
      chk({p, "_mem_lock"}, {15'd0, mem_lock}, 16'd0);
      chk({p, "_bus_err"}, {15'd0, bus_err}, 16'd0);
      chk({p, "_last_fetch"}, last_fetch, 16'd0);
   endtask

   // Drive one bus cycle, answer the memory port on cycle 'ack' (0 = never), compare to expectations.
   task automatic run_txn(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic ml,
                          input logic sy, input logic vp, input int ack, input logic [7:0] mrd,
                          input bit glitch, input int en, input logic [7:0] erd, input logic eoe,
                          input logic eerr);
      int n;
      @(negedge fclk);
      addr = a; rwb = rw; wdata = wd; mlb = ml; sync = sy; vpb = vp; phi2 = 1'b1;
      @(negedge fclk);
      if (sy) m_lf = a;
      chk("lock_launch", {15'd0, mem_lock}, {15'd0, ~ml});
      if (en > 0) begin
         chk("req_launch", {15'd0, mem_req}, 16'd1);
         chk("rdy_launch", {15'd0, rdy}, 16'd0);
         chk("mem_addr", mem_addr, a);
         chk("mem_we", {15'd0, mem_we}, {15'd0, ~rw});
         chk("mem_wdata", {8'd0, mem_wdata}, {8'd0, wd});
      end else begin
         chk("vec_noreq", {15'd0, mem_req}, 16'd0);
         chk("vec_rdy", {15'd0, rdy}, 16'd1);
      end
      addr = 16'($urandom); wdata = 8'($urandom); rwb = ~rw; sync = 1'b0;
      n = 0;
      while ((mem_req || !rdy) && n < 300) begin
         n++;
         phi2 = (glitch && n == 1) ? 1'b0 : 1'b1;
         mem_ack = (n == ack);
         mem_rdata = (n == ack) ? mrd : 8'($urandom);
         @(negedge fclk);
         mem_ack = 1'b0;
      end
      chk("busy_cycles", 16'(n), 16'(en));
      chk("rdata", {8'd0, rdata}, {8'd0, erd});
      chk("rdata_oe", {15'd0, rdata_oe}, {15'd0, eoe});
      chk("bus_err", {15'd0, bus_err}, {15'd0, eerr});
      chk("last_fetch", last_fetch, m_lf);
      chk("lock_done", {15'd0, mem_lock}, {15'd0, ~ml});
      if (en > 0) chk("mem_addr_held", mem_addr, a);
      phi2 = 1'b0;
      @(negedge fclk);
      chk("oe_drop", {15'd0, rdata_oe}, 16'd0);
      chk("rdata_keep", {8'd0, rdata}, {8'd0, erd});
      m_rdata = erd;
      m_err = eerr;
   endtask

   typedef struct {
      logic [15:0] a; logic rw; logic [7:0] wd; logic ml, sy, vp;
      int ack; logic [7:0] mrd; int en; logic [7:0] erd; logic eoe, eerr;
   } vec_t;
   vec_t tbl[11];

   initial begin
      int ack, en;
      logic [15:0] a, v;
      logic [7:0] erd, mrd;
      logic rw, eerr, is_vec;
      bit bad;
      tbl[0]  = '{16'h1234, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 3,  8'h5A, 3,  8'h5A, 1'b1, 1'b0};
      tbl[1]  = '{16'h0200, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1, 1,  8'h00, 1,  8'h5A, 1'b0, 1'b0};
`ifdef BUS_RESPONDER_VECTOR_OVERRIDE_EN
      tbl[2]  = '{16'hFFFC, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1,  8'h11, 0,  8'h00, 1'b1, 1'b0};
      tbl[3]  = '{16'hFFFD, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2,  8'h22, 0,  8'hE0, 1'b1, 1'b0};
`else
      tbl[2]  = '{16'hFFFC, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1,  8'h11, 1,  8'h11, 1'b1, 1'b0};
      tbl[3]  = '{16'hFFFD, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2,  8'h22, 2,  8'h22, 1'b1, 1'b0};
`endif
      tbl[4]  = '{16'hFFF9, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1,  8'h33, 1,  8'h33, 1'b1, 1'b0};
      tbl[5]  = '{16'h4000, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0,  8'h00, T,  8'hEA, 1'b1, 1'b1};
      tbl[6]  = '{16'h4001, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, T,  8'h77, T,  8'h77, 1'b1, 1'b1};
      tbl[7]  = '{16'h0300, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1,  8'h40, 1,  8'h40, 1'b1, 1'b1};
      tbl[8]  = '{16'h0300, 1'b0, 8'h41, 1'b0, 1'b0, 1'b1, 2,  8'h00, 2,  8'h40, 1'b0, 1'b1};
      tbl[9]  = '{16'hE000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1,  8'hA9, 1,  8'hA9, 1'b1, 1'b1};
      tbl[10] = '{16'hFFFC, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, 1,  8'h00, 1,  8'hA9, 1'b0, 1'b1};

      // reset with phi2 already high, then release: no launch may follow
      repeat (3) @(negedge fclk);
      chk_reset("reset");
      resb = 1'b1;
      bad = 1'b0;
      repeat (4) begin
         @(negedge fclk);
         if (mem_req || !rdy) bad = 1'b1;
      end
      chk("no_launch_at_release", {15'd0, bad}, 16'd0);
      phi2 = 1'b0;

      // ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 8'h99;
      repeat (2) @(negedge fclk);
      mem_ack = 1'b0;
      chk("idle_ack_req", {15'd0, mem_req}, 16'd0);
      chk("idle_ack_rdy", {15'd0, rdy}, 16'd1);
      chk("idle_ack_rdata", {8'd0, rdata}, 16'd0);

      foreach (tbl[i])
         run_txn(tbl[i].a, tbl[i].rw, tbl[i].wd, tbl[i].ml, tbl[i].sy, tbl[i].vp, tbl[i].ack,
                 tbl[i].mrd, i == 0, tbl[i].en, tbl[i].erd, tbl[i].eoe, tbl[i].eerr);

      // reset in the middle of a wait
      @(negedge fclk);
      addr = 16'h5555; rwb = 1'b1; sync = 1'b1; mlb = 1'b0; vpb = 1'b1; phi2 = 1'b1;
      repeat (3) @(negedge fclk);
      chk("mid_in_wait", {15'd0, mem_req}, 16'd1);
      #2 resb = 1'b0;
      #1 chk_reset("mid_reset");
      m_rdata = 8'd0; m_err = 1'b0; m_lf = 16'd0;
      @(negedge fclk);
      resb = 1'b1;
      bad = 1'b0;
      repeat (4) begin
         @(negedge fclk);
         if (mem_req || !rdy) bad = 1'b1;
      end
      chk("mid_no_relaunch", {15'd0, bad}, 16'd0);
      phi2 = 1'b0;

      // randomized transactions against a rule-level model
      for (int k = 0; k < 40; k++) begin
         a   = ($urandom_range(0, 1) == 1) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
         rw  = 1'($urandom);
         ack = $urandom_range(0, 18);
         mrd = 8'($urandom);
         is_vec = 1'b0;
`ifdef BUS_RESPONDER_VECTOR_OVERRIDE_EN
         is_vec = rw && a >= 16'hFFFA;
`endif
         eerr = m_err;
         if (is_vec && !1'(k & 1)) begin
            v   = a < 16'hFFFC ? 16'hE100 : a < 16'hFFFE ? 16'hE000 : 16'hE200;
            erd = a[0] ? v[15:8] : v[7:0];
            en  = 0;
         end else if (ack >= 1 && ack <= T) begin
            en  = ack;
            erd = rw ? mrd : m_rdata;
         end else begin
            en   = T;
            erd  = rw ? 8'hEA : m_rdata;
            eerr = 1'b1;
         end
         // odd k keeps vpb high so FFFA-FFFF are ordinary reads
         run_txn(a, rw, 8'($urandom), 1'($urandom), 1'($urandom), 1'(k & 1), ack, mrd,
                 (ack == 0 || ack >= 3) && 1'($urandom), en, erd, rw, eerr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the 65C02 core's external bus, at the far end of the interface driven by the core's decode/control logic (`phi2`, address, `rwb`, `sync`, `vpb`, `mlb`, data out). It sees the start of each bus cycle and turns it into a request/acknowledge transaction on a backing-memory port. While that transaction is outstanding it holds `rdy` low to stretch the core, then returns read data.

## Interface

Parameters:

- `TIMEOUT`, 8'd255 — `fclk` cycles `mem_req` may stay high without `mem_ack` before the transaction aborts.
- `NMI_VEC`, 16'hE100 — vector returned for FFFA/FFFB (override build only).
- `RST_VEC`, 16'hE000 — vector returned for FFFC/FFFD (override build only).
- `IRQ_VEC`, 16'hE200 — vector returned for FFFE/FFFF (override build only).

Ports:

- `fclk` in 1 — the single clock. One clock; reset is asynchronous and active-low.
- `resb` in 1 — asynchronous, active-low reset.
- `phi2` in 1 — the core's `id_phi2_out`, generated synchronously to `fclk`.
- `addr` in 16 — the core's address bus.
- `rwb` in 1 — 1 = read, 0 = write.
- `sync` in 1 — opcode fetch marker; used only by `last_fetch`.
- `vpb` in 1 — active-low vector pull.
- `mlb` in 1 — active-low memory lock (read-modify-write).
- `wdata` in 8 — core write data, valid at the `phi2` rise.
- `rdata` out 8 — read data to the core.
- `rdata_oe` out 1 — `rdata` is driven.
- `rdy` out 1 — 0 stretches the core.
- `mem_req` out 1 — request to backing memory.
- `mem_we` out 1 — write request.
- `mem_addr` out 16 — memory address.
- `mem_wdata` out 8 — memory write data.
- `mem_ack` in 1 — single-cycle acknowledge.
- `mem_rdata` in 8 — read data, valid with `mem_ack`.
- `mem_lock` out 1 — lock request to the arbiter.
- `bus_err` out 1 — sticky timeout flag.
- `last_fetch` out 16 — address of the most recent `sync` cycle.

## Operation

- States: IDLE, WAIT, DONE. `phi2_d` is a one-cycle delayed copy of `phi2`.
- **IDLE, launch.** Launch occurs on a rise (`phi2`=1 and `phi2_d`=0). At that edge:
  - `mem_addr`<=`addr`, `mem_we`<=~`rwb`, `mem_wdata`<=`wdata`, `mem_req`<=1, `rdy`<=0;
  - latch `rwb`; clear the wait counter;
  - `mem_lock`<=~`mlb`;
  - if `sync`=1, `last_fetch`<=`addr`;
  - go to WAIT.
- **WAIT.** The counter increments each cycle.
  - `mem_ack`=1: `mem_req`<=0, `rdy`<=1. On a read, also `rdata`<=`mem_rdata` and `rdata_oe`<=1. Go to DONE.
  - Counter reaches `TIMEOUT` with no ack: `mem_req`<=0, `rdy`<=1, `bus_err`<=1. On a read, `rdata`<=8'hEA (NOP) and `rdata_oe`<=1. Go to DONE.
  - `mem_ack` and timeout in the same cycle: the ack wins.
- **DONE.** When `phi2`=0 (level), `rdata_oe`<=0 and go to IDLE. `rdata` keeps its last value.
- `mem_ack` while `mem_req`=0 is ignored.
- `phi2` edges during WAIT are ignored; the core is stretched.
- `mem_lock` stays set across consecutive launches with `mlb`=0. It clears at the first launch with `mlb`=1.
- `bus_err` clears only on reset.

## Timing

- Reset values:
  - `rdata`=0, `rdata_oe`=0, `rdy`=1;
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `mem_lock`=0, `bus_err`=0, `last_fetch`=0;
  - state IDLE, counter 0, `phi2_d`=1. With `phi2_d` at 1, a `phi2` already high at reset release does not launch.
- All outputs are registered. `mem_req` and `rdy`=0 are visible in the cycle after the launch edge.
- Minimum read latency: with an ack in the first `mem_req` cycle, `rdy`=1 and `rdata` are valid two `fclk` edges after launch.
- Reset mid-transaction clears all outputs immediately (asynchronously). The backing memory must tolerate an abandoned request.

## Configuration

- `BUS_RESPONDER_VECTOR_OVERRIDE_EN` defined:
  - applies to a launch with `rwb`=1, `vpb`=0 and `addr` in FFFA–FFFF;
  - no `mem_req` is issued and `rdy` stays 1;
  - `rdata`<=the matching vector byte (even address = low byte, odd address = high byte), `rdata_oe`<=1;
  - go directly to DONE.
- Macro undefined: vector pulls are ordinary memory reads, and the `*_VEC` parameters are unused.

## Structure

- `bus_responder_pkg` holds:
  - the state enum;
  - `VEC_NMI_LO`=16'hFFFA, `VEC_RST_LO`=16'hFFFC, `VEC_IRQ_LO`=16'hFFFE;
  - `NOP_OPCODE`=8'hEA.
- One sub-module, `bus_vector_rom`: combinational vector-byte select, instantiated only under the macro. Edge detection and the FSM stay in the top.

## Test plan

1. **Read.** Read 16'h1234; `mem_ack` with `mem_rdata`=8'h5A on the third `mem_req` cycle. Required: `mem_we`=0; `rdy` low for exactly 3 cycles; then `rdata`=8'h5A and `rdata_oe`=1; `rdata_oe` drops when `phi2` falls.
2. **Write.** Write 8'hC3 to 16'h0200; ack on the first cycle. Required: `mem_we`=1, `mem_addr`=16'h0200, `mem_wdata`=8'hC3; `rdata_oe` stays 0.
3. **Vector override.** `vpb`=0 reads of FFFC then FFFD, macro defined. Required: `mem_req` never asserts, `rdy` stays 1, `rdata`=8'h00 then 8'hE0. Same stimulus with the macro undefined: two normal `mem_req` reads.
4. **Timeout.** `TIMEOUT`=16, read with no ack. Required: `mem_req` drops after 16 cycles, `rdata`=8'hEA, `bus_err`=1; `bus_err` persists through a later good transaction.
5. **Lock.** RMW read and write launched with `mlb`=0, then a launch with `mlb`=1. Required: `mem_lock`=1 across both RMW transactions, 0 after the third launch. Also check `last_fetch` captures a `sync`=1 address of 16'hE000.
6. **Reset mid-transaction.** `resb` pulsed low during WAIT. Required: all outputs take their reset values immediately; no `mem_req` after release until a fresh `phi2` rise.
